// File: rtl/block_memory_arbiter.sv
// -----------------------------------------------------------------------------
// block_memory_arbiter
//
// Shares one single-port block_memory between two requesters. Port 0 is the
// CPU data path and port 1 is the program loader / debug port. Requests are
// arbitrated round-robin. Only one transaction is in flight at a time.
// A store that does not cover the whole word is done as read-modify-write,
// so the bytes outside the mask keep their old value.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   req/we/mask/addr/wdataN requester N command. It must be held until doneN.
//   doneN                   one-cycle completion pulse for requester N
//   rdataN                  last read result for requester N
//   mem_*                   interface to block_memory. Reads return data one
//                           cycle after mem_read_enable.
//   busy                    high while a transaction is in progress
//   grant                   port that owns the current or most recent
//                           transaction
// -----------------------------------------------------------------------------
module block_memory_arbiter #(
  parameter int ADDRESS_SIZE = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic                    req0,
  input  logic                    we0,
  input  logic [3:0]              mask0,
  input  logic [ADDRESS_SIZE-1:0] addr0,
  input  logic [31:0]             wdata0,
  output logic                    done0,
  output logic [31:0]             rdata0,

  input  logic                    req1,
  input  logic                    we1,
  input  logic [3:0]              mask1,
  input  logic [ADDRESS_SIZE-1:0] addr1,
  input  logic [31:0]             wdata1,
  output logic                    done1,
  output logic [31:0]             rdata1,

  output logic                    mem_read_enable,
  output logic                    mem_write_enable,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [31:0]             mem_write_data,
  input  logic [31:0]             mem_read_data,

  output logic                    busy,
  output logic                    grant
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    port_q, port_d;       // port owning the transaction
  logic                    last_q, last_d;       // last granted port (tie-break)
  logic                    we_q, we_d;
  logic [3:0]              mask_q, mask_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  // Holds the write data. For an RMW it is replaced by the merged word in
  // RD_WAIT, so WR always drives this register for both write kinds.
  logic [31:0]             data_q, data_d;
  logic [31:0]             rdata0_q, rdata0_d;
  logic [31:0]             rdata1_q, rdata1_d;

  logic [31:0]             merge_word;
  logic                    sel;

  // Byte-wise merge: masked lanes come from the new data and the other lanes
  // come from the word just read.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merge_word[8*gi +: 8] = mask_q[gi] ? data_q[8*gi +: 8]
                                              : mem_read_data[8*gi +: 8];
  end

  // If both ports request, the port not granted last time wins.
  assign sel = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    last_d   = last_q;
    we_d     = we_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          port_d = sel;
          last_d = sel;
          we_d   = sel ? we1    : we0;
          mask_d = sel ? mask1  : mask0;
          addr_d = sel ? addr1  : addr0;
          data_d = sel ? wdata1 : wdata0;
          if (!we_d)                  state_d = RD_ISSUE;
          else if (mask_d == 4'b1111) state_d = WR;
          else if (mask_d == 4'b0000) state_d = RESP;  // nothing to store
          else                        state_d = RD_ISSUE; // read-modify-write
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (we_q) begin
          data_d  = merge_word;
          state_d = WR;
        end else begin
          if (port_q) rdata1_d = mem_read_data;
          else        rdata0_d = mem_read_data;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      last_q   <= 1'b1;   // so that port 0 wins the first tie
      we_q     <= 1'b0;
      mask_q   <= 4'b0000;
      addr_q   <= '0;
      data_q   <= 32'h0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      last_q   <= last_d;
      we_q     <= we_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // All strobes decode from registered state only, so no req input has a
  // combinational path to the memory or the requester outputs.
  assign mem_read_enable  = (state_q == RD_ISSUE);
  assign mem_write_enable = (state_q == WR);
  assign mem_address      = addr_q;
  assign mem_write_data   = data_q;
  assign busy             = (state_q != IDLE);
  assign grant            = port_q;
  assign done0            = (state_q == RESP) && !port_q;
  assign done1            = (state_q == RESP) &&  port_q;
  assign rdata0           = rdata0_q;
  assign rdata1           = rdata1_q;

endmodule

// File: tb/tb_block_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_block_memory_arbiter
//
// Directed bench for block_memory_arbiter. It contains a behavioural
// block_memory with a one-cycle registered read. Inputs change 1 ns after a
// rising edge, and outputs are checked at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_block_memory_arbiter;

  localparam int AW = 10;

  logic          clk;
  logic          reset_n;
  logic          req0, we0, req1, we1;
  logic [3:0]    mask0, mask1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          done0, done1;
  logic [31:0]   rdata0, rdata1;
  logic          mem_read_enable, mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;
  logic          busy, grant;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  block_memory_arbiter #(.ADDRESS_SIZE(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .mask0(mask0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .mask1(mask1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .busy(busy), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with a one-cycle registered read.
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= mem[mem_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done0 || done1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_timeout"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'b0, busy}, 32'd0);
    check({tag, "_re"},    {31'b0, mem_read_enable}, 32'd0);
    check({tag, "_we"},    {31'b0, mem_write_enable}, 32'd0);
    check({tag, "_done"},  {30'b0, done1, done0}, 32'd0);
    check({tag, "_grant"}, {31'b0, grant}, 32'd0);
    check({tag, "_addr"},  {22'b0, mem_address}, 32'd0);
    check({tag, "_wdata"}, mem_write_data, 32'd0);
    check({tag, "_rd0"},   rdata0, 32'd0);
    check({tag, "_rd1"},   rdata1, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    mem_read_data = 32'h0;
    reset_n = 1'b0;
    req0 = 0; we0 = 0; mask0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; mask1 = 0; addr1 = 0; wdata1 = 0;
    #2;
    check_all_zero("reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // ---- Port 0 read of mem[5] ----
    mem[5] = 32'hDEADBEEF;
    req0 = 1; we0 = 0; addr0 = 10'd5;              // T0
    check("rd_t0_busy", {31'b0, busy}, 32'd0);
    tick();                                         // T1
    check("rd_t1_re",   {31'b0, mem_read_enable}, 32'd1);
    check("rd_t1_addr", {22'b0, mem_address}, 32'd5);
    check("rd_t1_busy", {31'b0, busy}, 32'd1);
    tick();                                         // T2
    check("rd_t2_re",   {31'b0, mem_read_enable}, 32'd0);
    check("rd_t2_busy", {31'b0, busy}, 32'd1);
    check("rd_t2_done", {31'b0, done0}, 32'd0);
    tick();                                         // T3
    check("rd_t3_done0", {31'b0, done0}, 32'd1);
    check("rd_t3_done1", {31'b0, done1}, 32'd0);
    check("rd_t3_busy",  {31'b0, busy}, 32'd1);
    check("rd_t3_rdata", rdata0, 32'hDEADBEEF);
    req0 = 0;
    tick();
    check("rd_t4_done0", {31'b0, done0}, 32'd0);
    check("rd_t4_busy",  {31'b0, busy}, 32'd0);

    // ---- Port 1 full write to mem[3] ----
    req1 = 1; we1 = 1; mask1 = 4'b1111; addr1 = 10'd3; wdata1 = 32'h12345678;
    tick();                                         // T1
    check("wr_t1_we",    {31'b0, mem_write_enable}, 32'd1);
    check("wr_t1_re",    {31'b0, mem_read_enable}, 32'd0);
    check("wr_t1_data",  mem_write_data, 32'h12345678);
    check("wr_t1_addr",  {22'b0, mem_address}, 32'd3);
    check("wr_t1_grant", {31'b0, grant}, 32'd1);
    tick();                                         // T2
    check("wr_t2_done1", {31'b0, done1}, 32'd1);
    check("wr_t2_re",    {31'b0, mem_read_enable}, 32'd0);
    check("wr_t2_we",    {31'b0, mem_write_enable}, 32'd0);
    req1 = 0;
    tick();
    check("wr_mem3",     mem[3], 32'h12345678);
    check("wr_rdata1",   rdata1, 32'h0);

    // ---- Port 0 RMW on mem[7], byte lane 1 ----
    mem[7] = 32'hAABBCCDD;
    req0 = 1; we0 = 1; mask0 = 4'b0010; addr0 = 10'd7; wdata0 = 32'h0000EE00;
    tick();                                         // T1
    check("rmw_t1_re",   {31'b0, mem_read_enable}, 32'd1);
    check("rmw_t1_we",   {31'b0, mem_write_enable}, 32'd0);
    tick();                                         // T2
    check("rmw_t2_en",   {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
    tick();                                         // T3
    check("rmw_t3_we",   {31'b0, mem_write_enable}, 32'd1);
    check("rmw_t3_data", mem_write_data, 32'hAABBEEDD);
    check("rmw_t3_done", {31'b0, done0}, 32'd0);
    tick();                                         // T4
    check("rmw_t4_done0", {31'b0, done0}, 32'd1);
    check("rmw_t4_rd0",   rdata0, 32'hDEADBEEF);    // writes never touch rdata
    req0 = 0;
    tick();
    check("rmw_mem7", mem[7], 32'hAABBEEDD);
    req0 = 1; we0 = 0; addr0 = 10'd7;
    tick();
    wait_done("rmw_readback");
    check("rmw_readback", rdata0, 32'hAABBEEDD);
    req0 = 0;
    tick();

    // ---- Tie after reset: four reads alternate 0,1,0,1 ----
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    mem[20] = 32'h00C0FFEE;
    mem[21] = 32'h0BADF00D;
    req0 = 1; we0 = 0; addr0 = 10'd20;
    req1 = 1; we1 = 0; addr1 = 10'd21;
    tick();
    for (int k = 0; k < 4; k++) begin
      wait_done("rr");
      check("rr_grant", {31'b0, grant}, k % 2);
      check("rr_done0", {31'b0, done0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_done1", {31'b0, done1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 0) check("rr_rdata0", rdata0, 32'h00C0FFEE);
      else            check("rr_rdata1", rdata1, 32'h0BADF00D);
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
      tick();
    end
    check("rr_idle", {31'b0, busy}, 32'd0);

    // ---- Port 1 zero-mask write: done at T1, no memory access ----
    req1 = 1; we1 = 1; mask1 = 4'b0000; addr1 = 10'd3; wdata1 = 32'hFFFFFFFF;
    check("z_t0_en", {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
    tick();                                         // T1
    check("z_t1_done1", {31'b0, done1}, 32'd1);
    check("z_t1_en",    {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
    req1 = 0;
    tick();
    check("z_t2_en",    {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
    check("z_t2_done1", {31'b0, done1}, 32'd0);
    check("z_mem3",     mem[3], 32'h12345678);

    // ---- Reset during RMW RD_WAIT ----
    mem[9] = 32'h11223344;
    req0 = 1; we0 = 1; mask0 = 4'b0001; addr0 = 10'd9; wdata0 = 32'h000000AA;
    tick();                                         // T1
    check("rst_t1_re", {31'b0, mem_read_enable}, 32'd1);
    tick();                                         // T2 (RD_WAIT)
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    req0 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_hold", {29'b0, mem_write_enable, done0, done1}, 32'd0);
    end
    check("rst_mem9", mem[9], 32'h11223344);
    reset_n = 1'b1;
    req0 = 1; we0 = 0; addr0 = 10'd9;
    req1 = 1; we1 = 0; addr1 = 10'd5;
    tick();
    check("rst_tie_grant", {31'b0, grant}, 32'd0);
    check("rst_tie_addr",  {22'b0, mem_address}, 32'd9);
    wait_done("rst_tie");
    check("rst_tie_done0", {31'b0, done0}, 32'd1);
    check("rst_tie_rd0",   rdata0, 32'h11223344);
    req0 = 0; req1 = 0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/block_memory_arbiter.md
Name: block_memory_arbiter

Overview:
- Shares the single-port `block_memory` between two requesters: port 0 (CPU data path) and port 1 (program loader / debug).
- Arbitrates round-robin and runs one transaction at a time.
- Sub-word stores are done as read-modify-write (RMW) using byte masks, so adjacent bytes are never clobbered.
- Sits between the requesters and `block_memory` (1-cycle registered read latency).

Parameters:
- ADDRESS_SIZE, 10, word-address width of `block_memory`; all address ports use this width.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; sampled only in IDLE
- we0  in  1  port 0: 1 = write, 0 = read
- mask0  in  4  port 0 byte enables; bit i covers bits [8i+7:8i]; ignored for reads
- addr0  in  ADDRESS_SIZE  port 0 word address
- wdata0  in  32  port 0 write data, already lane-aligned
- done0  out  1  port 0 one-cycle completion pulse
- rdata0  out  32  port 0 read result
- req1, we1, mask1, addr1, wdata1, done1, rdata1: same as port 0, for port 1
- mem_read_enable  out  1  to `block_memory`
- mem_write_enable  out  1  to `block_memory`
- mem_address  out  ADDRESS_SIZE  shared read/write address to `block_memory`
- mem_write_data  out  32  to `block_memory`
- mem_read_data  in  32  from `block_memory`; valid the cycle after mem_read_enable
- busy  out  1  high whenever state is not IDLE
- grant  out  1  port owning the current or most recent transaction

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; all outputs go to 0 immediately.
  - Last-grant pointer set to 1, so port 0 wins the first tie.
  - Any in-flight transaction is abandoned: no done pulse, and no write unless the write edge has already occurred.
- States: IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
- IDLE:
  - If no req: stay in IDLE.
  - If exactly one req: that port is granted.
  - If both req: the port not granted last time wins; pointer updates on every grant.
  - On grant, latch we/mask/addr/wdata and the port id. Then:
    - read → RD_ISSUE
    - write with mask=4'b1111 → WR
    - write with mask=4'b0000 → RESP (no memory access)
    - any other write mask → RD_ISSUE (RMW)
- RD_ISSUE: mem_read_enable=1 → RD_WAIT.
- RD_WAIT: capture mem_read_data.
  - Read: load rdataN → RESP.
  - RMW: build merge_word = byte-wise (mask ? wdata : mem_read_data) → WR.
- WR:
  - mem_write_enable=1 for exactly one cycle.
  - mem_write_data = wdata for a full write, merge_word for RMW.
  - → RESP.
- RESP: doneN=1 for the granted port for exactly one cycle → IDLE.
- Latency, counted from the IDLE cycle that samples req (T0):
  - read: done at T3
  - full write: done at T2
  - RMW: done at T4
  - zero-mask write: done at T1
- Memory-side signals:
  - mem_* enables, done and busy decode from registered state only; no combinational path from req inputs.
  - mem_address holds the latched address for the whole transaction, including RESP.
  - At most one of mem_read_enable / mem_write_enable is high in any cycle.
- Read data: rdataN holds its value until the next read completion on that port; writes never change rdataN.
- Requester rules:
  - Hold req and its fields until done.
  - A req still high in the IDLE cycle after done is a new request.
  - A req raised outside IDLE waits; it is not lost and is not queued.
- Back-to-back requests: a waiting port is served at the next IDLE, so worst-case wait is one full transaction.

Test Plan:
- Port 0 read, mem[5]=0xDEADBEEF, req0 at T0 → mem_read_enable=1 with address 5 at T1; done0=1 at T3; rdata0=0xDEADBEEF; busy high T1–T3.
- Port 1 write, addr 3, mask 1111, wdata 0x12345678 → mem_write_enable=1 at T1 with data 0x12345678; mem_read_enable never high; done1 at T2.
- Port 0 RMW, mem[7]=0xAABBCCDD, mask 0010, wdata 0x0000EE00 → read at T1, write at T3 with data 0xAABBEEDD, done0 at T4; then a read of addr 7 returns 0xAABBEEDD.
- req0 and req1 held high together for four reads after reset → grant order 0,1,0,1; each port's done only for its own transaction.
- Port 1 write with mask 0000 → done1 at T1; no memory enable in any cycle; mem[addr] unchanged.
- reset_n pulled low during RMW RD_WAIT (T2) → all outputs 0 asynchronously; no write occurs and no done pulse. After release, a tie is granted to port 0.
